// File: rtl/mem_stage.sv
// Memory pipeline stage: captures an EX instruction, issues one data-SRAM access
// for loads/stores, formats load data and hands the result to WB.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_to_mem_valid,
    output logic        o_mem_ready,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [2:0]  ex_mem_op,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_rf_we,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        i_wb_ready,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_result,
    output logic [4:0]  mem_rf_waddr,
    output logic        mem_rf_we,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_inst,
    output logic        mem_load_busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        cap_re, cap_we, cap_rf_we;
    logic [2:0]  cap_op;
    logic [31:0] cap_addr, cap_sd, cap_pc, cap_inst, result;
    logic [4:0]  cap_waddr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt     = state;
        o_mem_ready   = 1'b0;
        accept        = 1'b0;
        data_sram_req = 1'b0;
        case (state)
            IDLE: o_mem_ready = 1'b1;
            DONE: o_mem_ready = i_wb_ready;
            default: o_mem_ready = 1'b0;
        endcase
        accept = ex_to_mem_valid & o_mem_ready;
        case (state)
            IDLE: if (accept) state_nxt = (ex_mem_re | ex_mem_we) ? REQ : DONE;
            REQ: begin
                data_sram_req = 1'b1;
                if (data_sram_addr_ok) state_nxt = WAIT;
            end
            WAIT: if (data_sram_data_ok) state_nxt = DONE;
            DONE: begin
                if (i_wb_ready) begin
                    if (accept) state_nxt = (ex_mem_re | ex_mem_we) ? REQ : DONE;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Captured instruction fields and stage result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_re    <= 1'b0;
            cap_we    <= 1'b0;
            cap_op    <= 3'd0;
            cap_addr  <= 32'd0;
            cap_sd    <= 32'd0;
            cap_waddr <= 5'd0;
            cap_rf_we <= 1'b0;
            cap_pc    <= 32'd0;
            cap_inst  <= 32'd0;
            result    <= 32'd0;
        end else if (accept) begin
            cap_re    <= ex_mem_re;
            cap_we    <= ex_mem_we;
            cap_op    <= ex_mem_op;
            cap_addr  <= ex_alu_res;
            cap_sd    <= ex_store_data;
            cap_waddr <= ex_rf_waddr;
            cap_rf_we <= ex_rf_we;
            cap_pc    <= ex_pc;
            cap_inst  <= ex_inst;
            result    <= ex_alu_res;
        end else if (state == WAIT && data_sram_data_ok) begin
            result <= cap_we ? cap_addr : load_val;
        end
    end

    // Load lane selection and extension
    always_comb begin
        case (cap_addr[1:0])
            2'd0:    byte_sel = data_sram_rdata[7:0];
            2'd1:    byte_sel = data_sram_rdata[15:8];
            2'd2:    byte_sel = data_sram_rdata[23:16];
            default: byte_sel = data_sram_rdata[31:24];
        endcase
        half_sel = cap_addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (cap_op[1:0])
            2'b00:   load_val = cap_op[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = cap_op[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = data_sram_rdata;
        endcase
    end

    // Request fields, strobes and replicated store data
    always_comb begin
        data_sram_wr    = cap_we;
        data_sram_size  = cap_op[1:0];
        data_sram_addr  = (cap_op[1:0] == 2'b10) ? {cap_addr[31:2], 2'b00} : cap_addr;
        data_sram_wstrb = 4'b0000;
        case (cap_op[1:0])
            2'b00: begin
                data_sram_wdata = {4{cap_sd[7:0]}};
                if (cap_we) data_sram_wstrb = 4'b0001 << cap_addr[1:0];
            end
            2'b01: begin
                data_sram_wdata = {2{cap_sd[15:0]}};
                if (cap_we) data_sram_wstrb = cap_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data_sram_wdata = cap_sd;
                if (cap_we) data_sram_wstrb = 4'b1111;
            end
        endcase
    end

    assign mem_to_wb_valid = (state == DONE);
    assign mem_rf_we       = cap_rf_we & mem_to_wb_valid;
    assign mem_load_busy   = cap_re & ((state == REQ) | (state == WAIT));
    assign mem_result      = result;
    assign mem_rf_waddr    = cap_waddr;
    assign mem_pc          = cap_pc;
    assign mem_inst        = cap_inst;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, stores,
// WB backpressure, back-to-back accept and reset during an access.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_to_mem_valid, o_mem_ready, ex_mem_re, ex_mem_we;
    logic [2:0]  ex_mem_op;
    logic [31:0] ex_alu_res, ex_store_data, ex_pc, ex_inst;
    logic [4:0]  ex_rf_waddr;
    logic        ex_rf_we;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        data_sram_addr_ok, data_sram_data_ok, i_wb_ready;
    logic        mem_to_wb_valid, mem_rf_we, mem_load_busy;
    logic [31:0] mem_result, mem_pc, mem_inst;
    logic [4:0]  mem_rf_waddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_to_mem_valid(ex_to_mem_valid), .o_mem_ready(o_mem_ready),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_mem_op(ex_mem_op),
        .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
        .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we),
        .ex_pc(ex_pc), .ex_inst(ex_inst),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .i_wb_ready(i_wb_ready),
        .mem_to_wb_valid(mem_to_wb_valid), .mem_result(mem_result),
        .mem_rf_waddr(mem_rf_waddr), .mem_rf_we(mem_rf_we),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_load_busy(mem_load_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction while the stage is ready; returns one edge later
    task automatic issue(input logic re, input logic we, input logic [2:0] op,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] wa, input logic rfwe);
        ex_to_mem_valid = 1'b1;
        ex_mem_re = re; ex_mem_we = we; ex_mem_op = op;
        ex_alu_res = alu; ex_store_data = sd;
        ex_rf_waddr = wa; ex_rf_we = rfwe;
        ex_pc = alu + 32'h100; ex_inst = ~alu;
        cyc();
        ex_to_mem_valid = 1'b0;
        ex_mem_re = 1'b0; ex_mem_we = 1'b0;
    endtask

    // From REQ: grant address immediately, return data next cycle, land in DONE
    task automatic finish_mem(input logic [31:0] rd);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = rd;
        cyc();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_to_mem_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_mem_op = 3'd0;
        ex_alu_res = '0; ex_store_data = '0; ex_rf_waddr = '0; ex_rf_we = 1'b0;
        ex_pc = '0; ex_inst = '0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        i_wb_ready = 1'b1;
        cyc(); cyc();
        #1;
        check("rst_ready", 32'(o_mem_ready), 32'd1);
        check("rst_valid", 32'(mem_to_wb_valid), 32'd0);
        check("rst_req", 32'(data_sram_req), 32'd0);
        check("rst_result", mem_result, 32'd0);
        check("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
        check("rst_busy", 32'(mem_load_busy), 32'd0);
        rst_n = 1'b1;
        cyc();

        // ALU pass-through
        issue(1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1);
        #1;
        check("alu_valid", 32'(mem_to_wb_valid), 32'd1);
        check("alu_result", mem_result, 32'h1234);
        check("alu_rfwe", 32'(mem_rf_we), 32'd1);
        check("alu_waddr", 32'(mem_rf_waddr), 32'd5);
        check("alu_pc", mem_pc, 32'h1334);
        cyc();
        #1;
        check("alu_idle", 32'(mem_to_wb_valid), 32'd0);

        // Signed byte load; addr_ok on third REQ cycle alongside a stray data_ok
        issue(1'b1, 1'b0, 3'b000, 32'h1003, 32'd0, 5'd7, 1'b1);
        #1;
        check("ldb_req1", 32'(data_sram_req), 32'd1);
        check("ldb_size", 32'(data_sram_size), 32'd0);
        check("ldb_addr", data_sram_addr, 32'h1003);
        check("ldb_wstrb", 32'(data_sram_wstrb), 32'd0);
        check("ldb_wr", 32'(data_sram_wr), 32'd0);
        check("ldb_busy1", 32'(mem_load_busy), 32'd1);
        check("ldb_ready", 32'(o_mem_ready), 32'd0);
        cyc();
        #1;
        check("ldb_req2", 32'(data_sram_req), 32'd1);
        cyc();
        data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        #1;
        check("ldb_req3", 32'(data_sram_req), 32'd1);
        cyc();
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        check("ldb_wait_req", 32'(data_sram_req), 32'd0);
        check("ldb_wait_valid", 32'(mem_to_wb_valid), 32'd0);
        check("ldb_busy2", 32'(mem_load_busy), 32'd1);
        cyc();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF00;
        cyc();
        data_sram_data_ok = 1'b0;
        #1;
        check("ldb_valid", 32'(mem_to_wb_valid), 32'd1);
        check("ldb_result", mem_result, 32'hFFFF_FF80);
        check("ldb_busy3", 32'(mem_load_busy), 32'd0);
        check("ldb_rfwe", 32'(mem_rf_we), 32'd1);
        cyc();

        // Halfword store, then WB backpressure and back-to-back accept
        issue(1'b0, 1'b1, 3'b001, 32'h2002, 32'hAABB_CCDD, 5'd0, 1'b0);
        #1;
        check("sth_wstrb", 32'(data_sram_wstrb), 32'hC);
        check("sth_wdata", data_sram_wdata, 32'hCCDD_CCDD);
        check("sth_wr", 32'(data_sram_wr), 32'd1);
        check("sth_size", 32'(data_sram_size), 32'd1);
        check("sth_busy", 32'(mem_load_busy), 32'd0);
        finish_mem(32'h0);
        i_wb_ready = 1'b0;
        ex_to_mem_valid = 1'b1; ex_alu_res = 32'h55AA; ex_rf_waddr = 5'd9; ex_rf_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_ready", 32'(o_mem_ready), 32'd0);
            check("bp_valid", 32'(mem_to_wb_valid), 32'd1);
            check("bp_result", mem_result, 32'h2002);
            check("bp_rfwe", 32'(mem_rf_we), 32'd0);
            cyc();
        end
        i_wb_ready = 1'b1;
        #1;
        check("b2b_ready", 32'(o_mem_ready), 32'd1);
        cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        check("b2b_valid", 32'(mem_to_wb_valid), 32'd1);
        check("b2b_result", mem_result, 32'h55AA);
        check("b2b_waddr", 32'(mem_rf_waddr), 32'd9);
        check("b2b_rfwe", 32'(mem_rf_we), 32'd1);
        cyc();

        // Byte store at offset 1
        issue(1'b0, 1'b1, 3'b000, 32'h3001, 32'h1234_56EF, 5'd0, 1'b0);
        #1;
        check("stb_wstrb", 32'(data_sram_wstrb), 32'h2);
        check("stb_wdata", data_sram_wdata, 32'hEFEF_EFEF);
        finish_mem(32'h0);
        #1;
        check("stb_result", mem_result, 32'h3001);
        cyc();

        // Misaligned word load: address is word-aligned, data unchanged
        issue(1'b1, 1'b0, 3'b010, 32'h4007, 32'd0, 5'd4, 1'b1);
        #1;
        check("ldw_addr", data_sram_addr, 32'h4004);
        check("ldw_size", 32'(data_sram_size), 32'd2);
        finish_mem(32'hCAFE_F00D);
        #1;
        check("ldw_result", mem_result, 32'hCAFE_F00D);
        cyc();

        // Unsigned upper half, then signed lower half
        issue(1'b1, 1'b0, 3'b101, 32'h0002, 32'd0, 5'd6, 1'b1);
        finish_mem(32'h8001_0000);
        #1;
        check("ldhu_result", mem_result, 32'h0000_8001);
        cyc();
        issue(1'b1, 1'b0, 3'b001, 32'h0000, 32'd0, 5'd6, 1'b1);
        finish_mem(32'h0001_8000);
        #1;
        check("ldh_result", mem_result, 32'hFFFF_8000);
        cyc();

        // Reset while waiting for data; late data_ok must be ignored
        issue(1'b1, 1'b0, 3'b010, 32'h0100, 32'd0, 5'd3, 1'b1);
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        #1;
        check("rstw_ready", 32'(o_mem_ready), 32'd1);
        check("rstw_valid", 32'(mem_to_wb_valid), 32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        #1;
        check("rstw_valid2", 32'(mem_to_wb_valid), 32'd0);
        check("rstw_result", mem_result, 32'd0);
        check("rstw_waddr", 32'(mem_rf_waddr), 32'd0);
        check("rstw_busy", 32'(mem_load_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
